// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
//   Stage index names for the classic 5-stage RV32I pipe, the default
//   counter width, and a stage bit-vector type wide enough for the
//   largest legal pipeline (8 stages).
package pipe_ctrl_pkg;

   localparam int F_STAGE = 0;
   localparam int D_STAGE = 1;
   localparam int E_STAGE = 2;
   localparam int M_STAGE = 3;
   localparam int W_STAGE = 4;

   localparam int CNT_W_DEFAULT = 64;
   localparam int MAX_STAGES    = 8;

   typedef logic [MAX_STAGES-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_ctrl_counter.sv
// pipe_ctrl_counter: free-running W-bit up-counter, wraps modulo 2^W.
//   clk   - clock
//   reset - synchronous, active-high clear
//   en    - count enable
//   count - current value
module pipe_ctrl_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int W = CNT_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage valid/enable sequencer and hazard controller for the
// RV32I core, plus the cycle/instret counters read through CSRRS.
//   clk          - clock
//   reset        - synchronous, active-high reset
//   stall_req    - per-stage "cannot complete this cycle"
//   redirect     - branch/jump taken by the instruction in BRANCH_STAGE
//   halt_req     - EBREAK present in HALT_STAGE
//   stage_valid  - stage holds a live instruction (one-hot token in SEQUENTIAL mode)
//   stage_en     - output register of the stage loads this cycle
//   pc_redirect  - fetch PC loads the branch target this cycle
//   halted       - sticky halt, cleared only by reset
//   cycle        - free-running cycle count
//   instret      - retired instruction count
// Optional (macro PIPE_CTRL_PERF_EN):
//   stall_cycles - cycles with a live instruction held by a stall
//   flush_count  - acknowledged redirects
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGES      = 5,
   parameter int BRANCH_STAGE = M_STAGE,
   parameter int HALT_STAGE   = E_STAGE,
   parameter int SEQUENTIAL   = 0,
   parameter int CNT_W        = CNT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NSTAGES-1:0] stall_req,
   input  logic               redirect,
   input  logic               halt_req,
   output logic [NSTAGES-1:0] stage_valid,
   output logic [NSTAGES-1:0] stage_en,
   output logic               pc_redirect,
   output logic               halted,
   output logic [CNT_W-1:0]   cycle,
   output logic [CNT_W-1:0]   instret
`ifdef PIPE_CTRL_PERF_EN
  ,output logic [CNT_W-1:0]   stall_cycles,
   output logic [CNT_W-1:0]   flush_count
`endif
);

   logic [NSTAGES-1:0] hold_eff;
   logic [NSTAGES-1:0] halt_block;
   logic [NSTAGES-1:0] valid_nxt;
   logic               halt_ack;
   logic               redirect_ack;
   logic               retire;

   assign halt_ack = halt_req & stage_valid[HALT_STAGE] & ~halted & ~reset;

   // The EBREAK stage and everything younger freeze in the halt cycle;
   // older stages may still drain in that one cycle.
   always_comb begin
      halt_block = '0;
      for (int i = 0; i < NSTAGES; i++) begin
         halt_block[i] = halt_ack && (i <= HALT_STAGE);
      end
   end

   always_comb begin
      hold_eff     = '0;
      stage_en     = '0;
      valid_nxt    = stage_valid;
      redirect_ack = 1'b0;
      retire       = 1'b0;
      if (SEQUENTIAL != 0) begin
         hold_eff = stall_req | halt_block;
         if (!reset && !halted) begin
            stage_en = stage_valid & ~hold_eff;
         end
         redirect_ack = redirect & stage_en[BRANCH_STAGE] & ~halt_ack;
         retire       = stage_en[NSTAGES-1];
         if (|stage_en) begin
            valid_nxt = {stage_valid[NSTAGES-2:0], stage_valid[NSTAGES-1]};
         end
      end else begin
         // A stall holds its own stage and every younger stage behind it.
         hold_eff[NSTAGES-1] = stall_req[NSTAGES-1] | halt_block[NSTAGES-1];
         for (int i = NSTAGES-2; i >= 0; i--) begin
            hold_eff[i] = stall_req[i] | halt_block[i] | hold_eff[i+1];
         end
         if (!reset && !halted) begin
            stage_en = ~hold_eff;
         end
         redirect_ack = redirect & stage_valid[BRANCH_STAGE] & stage_en[BRANCH_STAGE] & ~halt_ack;
         retire       = stage_valid[NSTAGES-1] & stage_en[NSTAGES-1];
         if (!halted) begin
            valid_nxt[0] = 1'b1;
            for (int i = 1; i < NSTAGES; i++) begin
               valid_nxt[i] = hold_eff[i] ? stage_valid[i]
                                          : (stage_valid[i-1] & ~hold_eff[i-1]);
            end
            // Squash the wrong-path instructions behind the taken branch.
            if (redirect_ack) begin
               for (int i = 1; i <= BRANCH_STAGE; i++) begin
                  valid_nxt[i] = 1'b0;
               end
            end
         end
      end
   end

   assign pc_redirect = redirect_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_valid <= NSTAGES'(1);
         halted      <= 1'b0;
      end else begin
         stage_valid <= valid_nxt;
         halted      <= halted | halt_ack;
      end
   end

   pipe_ctrl_counter #(.W(CNT_W)) u_cycle (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .count (cycle)
   );

   pipe_ctrl_counter #(.W(CNT_W)) u_instret (
      .clk   (clk),
      .reset (reset),
      .en    (retire),
      .count (instret)
   );

`ifdef PIPE_CTRL_PERF_EN
   logic [NSTAGES-1:0] hold_raw;
   logic               any_stall;

   // Stall accounting uses the stall chain only, not the halt freeze.
   always_comb begin
      hold_raw = '0;
      if (SEQUENTIAL != 0) begin
         hold_raw = stall_req;
      end else begin
         hold_raw[NSTAGES-1] = stall_req[NSTAGES-1];
         for (int i = NSTAGES-2; i >= 0; i--) begin
            hold_raw[i] = stall_req[i] | hold_raw[i+1];
         end
      end
   end

   assign any_stall = (|(hold_raw & stage_valid)) & ~halted;

   pipe_ctrl_counter #(.W(CNT_W)) u_stall_cycles (
      .clk   (clk),
      .reset (reset),
      .en    (any_stall),
      .count (stall_cycles)
   );

   pipe_ctrl_counter #(.W(CNT_W)) u_flush_count (
      .clk   (clk),
      .reset (reset),
      .en    (redirect_ack),
      .count (flush_count)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: drives a pipelined and a token-mode pipe_ctrl with shared
// inputs and compares both against instruction-level reference models.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int N  = 5;
   localparam int BS = 3;
   localparam int HS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [N-1:0] stall_req;
   logic         redirect;
   logic         halt_req;

   logic [N-1:0] p_valid, p_en, t_valid, t_en;
   logic         p_pcr, t_pcr, p_halted, t_halted;
   logic [63:0]  p_cycle, p_instret, t_cycle, t_instret;
`ifdef PIPE_CTRL_PERF_EN
   logic [63:0]  p_stall_cyc, p_flush, t_stall_cyc, t_flush;
`endif

   pipe_ctrl #(.NSTAGES(N), .BRANCH_STAGE(BS), .HALT_STAGE(HS), .SEQUENTIAL(0), .CNT_W(64)) u_pipe (
      .clk          (clk),
      .reset        (reset),
      .stall_req    (stall_req),
      .redirect     (redirect),
      .halt_req     (halt_req),
      .stage_valid  (p_valid),
      .stage_en     (p_en),
      .pc_redirect  (p_pcr),
      .halted       (p_halted),
      .cycle        (p_cycle),
      .instret      (p_instret)
`ifdef PIPE_CTRL_PERF_EN
     ,.stall_cycles (p_stall_cyc),
      .flush_count  (p_flush)
`endif
   );

   pipe_ctrl #(.NSTAGES(N), .BRANCH_STAGE(BS), .HALT_STAGE(HS), .SEQUENTIAL(1), .CNT_W(64)) u_tok (
      .clk          (clk),
      .reset        (reset),
      .stall_req    (stall_req),
      .redirect     (redirect),
      .halt_req     (halt_req),
      .stage_valid  (t_valid),
      .stage_en     (t_en),
      .pc_redirect  (t_pcr),
      .halted       (t_halted),
      .cycle        (t_cycle),
      .instret      (t_instret)
`ifdef PIPE_CTRL_PERF_EN
     ,.stall_cycles (t_stall_cyc),
      .flush_count  (t_flush)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pipelined model: each slot holds an instruction id, -1 when empty.
   int          m_slot[N];
   int          next_id = 0;
   bit          m_halted;
   logic [63:0] m_cycle, m_instret, m_stall, m_flush;
   logic [N-1:0] e_en;
   logic        e_pcr;
   bit          e_halt_hit;

   // Token model: position of the single live instruction.
   int          t_tok;
   bit          t_hlt;
   logic [63:0] t_cyc_m, t_inst_m, t_stall_m, t_flush_m;
   logic [N-1:0] te_en;
   logic        te_pcr;
   bit          te_halt_hit;

   task automatic model_comb();
      e_en = '0; e_pcr = 1'b0; e_halt_hit = 1'b0;
      te_en = '0; te_pcr = 1'b0; te_halt_hit = 1'b0;
      if (!reset && !m_halted) begin
         e_halt_hit = halt_req && (m_slot[HS] >= 0);
         for (int i = 0; i < N; i++) begin
            bit stuck;
            stuck = e_halt_hit && (i <= HS);
            for (int j = i; j < N; j++) if (stall_req[j]) stuck = 1'b1;
            e_en[i] = !stuck;
         end
         e_pcr = redirect && (m_slot[BS] >= 0) && e_en[BS] && !e_halt_hit;
      end
      if (!reset && !t_hlt) begin
         te_halt_hit = halt_req && (t_tok == HS);
         if (!stall_req[t_tok] && !te_halt_hit) te_en[t_tok] = 1'b1;
         te_pcr = redirect && te_en[BS] && !te_halt_hit;
      end
   endtask

   task automatic model_update();
      if (reset) begin
         for (int i = 0; i < N; i++) m_slot[i] = -1;
         m_slot[0] = next_id++;
         m_halted = 1'b0;
         m_cycle = '0; m_instret = '0; m_stall = '0; m_flush = '0;
         t_tok = 0; t_hlt = 1'b0;
         t_cyc_m = '0; t_inst_m = '0; t_stall_m = '0; t_flush_m = '0;
      end else begin
         m_cycle++;
         t_cyc_m++;
         if (!m_halted) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++)
               for (int j = i; j < N; j++)
                  if (m_slot[i] >= 0 && stall_req[j]) any = 1'b1;
            if (any) m_stall++;
         end
         if (e_pcr) m_flush++;
         for (int i = N-1; i >= 0; i--) begin
            if (e_en[i]) begin
               if (i == N-1) begin
                  if (m_slot[i] >= 0) m_instret++;
               end else begin
                  m_slot[i+1] = m_slot[i];
               end
               m_slot[i] = -1;
            end
         end
         if (e_en[0]) m_slot[0] = next_id++;
         if (e_pcr) for (int i = 1; i <= BS; i++) m_slot[i] = -1;
         if (e_halt_hit) m_halted = 1'b1;

         if (!t_hlt && stall_req[t_tok]) t_stall_m++;
         if (te_pcr) t_flush_m++;
         if (|te_en) begin
            if (t_tok == N-1) begin
               t_tok = 0;
               t_inst_m++;
            end else begin
               t_tok++;
            end
         end
         if (te_halt_hit) t_hlt = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] ev, tv;
      for (int i = 0; i < N; i++) ev[i] = (m_slot[i] >= 0);
      tv = '0;
      tv[t_tok] = 1'b1;
      chk("p_valid",   p_valid,   ev);
      chk("p_en",      p_en,      e_en);
      chk("p_pcr",     p_pcr,     e_pcr);
      chk("p_halted",  p_halted,  m_halted);
      chk("p_cycle",   p_cycle,   m_cycle);
      chk("p_instret", p_instret, m_instret);
      chk("t_valid",   t_valid,   tv);
      chk("t_en",      t_en,      te_en);
      chk("t_pcr",     t_pcr,     te_pcr);
      chk("t_halted",  t_halted,  t_hlt);
      chk("t_cycle",   t_cycle,   t_cyc_m);
      chk("t_instret", t_instret, t_inst_m);
`ifdef PIPE_CTRL_PERF_EN
      chk("p_stall_cycles", p_stall_cyc, m_stall);
      chk("p_flush_count",  p_flush,     m_flush);
      chk("t_stall_cycles", t_stall_cyc, t_stall_m);
      chk("t_flush_count",  t_flush,     t_flush_m);
`endif
   endtask

   task automatic apply(input logic [N-1:0] s, input logic r, input logic h, input logic rst);
      stall_req = s;
      redirect  = r;
      halt_req  = h;
      reset     = rst;
      #1;
      model_comb();
      check_outputs();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic step(input logic [N-1:0] s, input logic r, input logic h, input logic rst);
      apply(s, r, h, rst);
      tick();
   endtask

   initial begin
      reset = 1'b1; stall_req = '0; redirect = 1'b0; halt_req = 1'b0;
      repeat (2) @(posedge clk);
      model_update();
      @(negedge clk);

      // Reset state, and enables/redirect forced off while reset is high.
      apply('1, 1'b1, 1'b1, 1'b1);
      chk("rst_en",  p_en, '0);
      chk("rst_pcr", p_pcr, 1'b0);
      chk("rst_valid", p_valid, 5'b00001);
      tick();

      // Fill with no stalls.
      for (int k = 1; k <= 10; k++) begin
         step('0, 1'b0, 1'b0, 1'b0);
         if (k == 4)  chk("fill_full", p_valid, 5'b11111);
         if (k == 5)  chk("fill_instret5", p_instret, 64'd1);
         if (k == 10) chk("fill_instret10", p_instret, 64'd6);
      end

      // Stall stage 1 for two cycles with the pipe full.
      apply(5'b00010, 1'b0, 1'b0, 1'b0);
      chk("stall_en1", p_en, 5'b11100);
      tick();
      chk("stall_bubble", p_valid[2], 1'b0);
      apply(5'b00010, 1'b0, 1'b0, 1'b0);
      chk("stall_en2", p_en, 5'b11100);
      tick();
      repeat (3) step('0, 1'b0, 1'b0, 1'b0);
      chk("stall_refill", p_valid, 5'b11111);

      // Taken branch in stage 3.
      apply('0, 1'b1, 1'b0, 1'b0);
      chk("br_pcr", p_pcr, 1'b1);
      tick();
      chk("br_flush", p_valid, 5'b10001);
      apply('0, 1'b1, 1'b0, 1'b0);
      chk("br_unqualified", p_pcr, 1'b0);
      tick();
      repeat (3) step('0, 1'b0, 1'b0, 1'b0);
      apply(5'b01000, 1'b1, 1'b0, 1'b0);
      chk("br_stalled", p_pcr, 1'b0);
      tick();
      repeat (2) step('0, 1'b0, 1'b0, 1'b0);

      // Halt with a simultaneous redirect: halt wins, older stages drain.
      apply('0, 1'b1, 1'b1, 1'b0);
      chk("halt_en", p_en, 5'b11000);
      chk("halt_pcr", p_pcr, 1'b0);
      tick();
      chk("halt_set", p_halted, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(5'(k), 1'b1, 1'b1, 1'b0);
         chk("halt_frozen_en", p_en, '0);
      end
      step('0, 1'b0, 1'b0, 1'b1);
      chk("halt_clear", p_halted, 1'b0);
      chk("halt_instret0", p_instret, 64'd0);

      // Token mode: 15 idle cycles retire three instructions.
      for (int k = 1; k <= 15; k++) step('0, 1'b0, 1'b0, 1'b0);
      chk("tok_instret15", t_instret, 64'd3);
      repeat (2) step('0, 1'b0, 1'b0, 1'b0);
      step(5'b00100, 1'b0, 1'b0, 1'b0);
      repeat (2) step('0, 1'b0, 1'b0, 1'b0);
      chk("tok_delay_pos", t_valid, 5'b10000);
      chk("tok_delay_inst", t_instret, 64'd3);
      step('0, 1'b0, 1'b0, 1'b0);
      chk("tok_wrap", t_instret, 64'd4);

`ifdef PIPE_CTRL_PERF_EN
      step('0, 1'b0, 1'b0, 1'b1);
      repeat (4) step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(5'b00001, 1'b0, 1'b0, 1'b0);
      chk("perf_stall3", p_stall_cyc, 64'd3);
      chk("perf_flush2", p_flush, 64'd2);
      step('0, 1'b0, 1'b0, 1'b1);
      chk("perf_rst_stall", p_stall_cyc, 64'd0);
      chk("perf_rst_flush", p_flush, 64'd0);
`endif

      // Randomised traffic against both models.
      for (int c = 0; c < 800; c++) begin
         logic [N-1:0] s;
         logic r, h, rst;
         s = '0;
         for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) s[i] = 1'b1;
         r   = ($urandom_range(2) == 0);
         h   = ($urandom_range(25) == 0);
         rst = ((m_halted || t_hlt) && $urandom_range(5) == 0) || ($urandom_range(150) == 0);
         step(s, r, h, rst);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencer and hazard controller for the RV32I core.
- Replaces the fixed 5-bit rotating state register with per-stage valid/enable generation for N stages.
- Two modes: a one-instruction-in-flight token mode and a true pipelined mode with backward stall propagation, branch flush and sticky halt.
- Also owns the cycle and instret counters read by CSRRS.

Parameters:
- NSTAGES, 5: number of pipeline stages (F=0 … W=NSTAGES-1); legal range 3..8.
- BRANCH_STAGE, 3: stage that raises the redirect; range 1..NSTAGES-2.
- HALT_STAGE, 2: stage where EBREAK is detected; range 1..NSTAGES-1.
- SEQUENTIAL, 0: 1 = token mode, 0 = pipelined mode.
- CNT_W, 64: width of the cycle and instret counters.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- stall_req, in, NSTAGES: stall_req[i]=1 means stage i cannot complete this cycle.
- redirect, in, 1: jump/branch taken by the instruction in BRANCH_STAGE.
- halt_req, in, 1: EBREAK present in HALT_STAGE.
- stage_valid, out, NSTAGES: stage i holds a live instruction.
- stage_en, out, NSTAGES: the register at the output of stage i loads this cycle.
- pc_redirect, out, 1: fetch PC loads the branch target this cycle.
- halted, out, 1: sticky halt flag.
- cycle, out, CNT_W: free-running cycle count.
- instret, out, CNT_W: retired-instruction count.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - stage_valid = 1 in SEQUENTIAL mode (token at F); otherwise stage_valid[0]=1 and all others 0.
  - halted=0, cycle=0, instret=0.
  - stage_en and pc_redirect are combinational and forced to 0 while reset=1.
- cycle increments every non-reset cycle, including while halted. It wraps modulo 2^CNT_W.
- Pipelined mode (SEQUENTIAL=0):
  - hold[NSTAGES-1] = stall_req[NSTAGES-1].
  - For i < NSTAGES-1: hold[i] = stall_req[i] | hold[i+1].
  - stage_en[i] = !hold[i] & !halted & !reset.
  - stage_valid[0] is always 1 after reset (fetch is always live).
  - Next stage_valid[i+1] = hold[i+1] ? stage_valid[i+1] : (stage_valid[i] & !hold[i]). A holding stage with a free successor therefore emits a bubble.
  - redirect is acknowledged only when stage_valid[BRANCH_STAGE] & !hold[BRANCH_STAGE] & !halted; this sets pc_redirect=1.
  - On acknowledge: next stage_valid[1..BRANCH_STAGE] are forced 0, overriding the advance rule. The branch itself advances to BRANCH_STAGE+1 normally.
  - An unqualified redirect is ignored.
  - Retire: stage_valid[NSTAGES-1] & !hold[NSTAGES-1] & !halted increments instret by 1.
- Token mode (SEQUENTIAL=1):
  - stage_valid is a one-hot token.
  - stage_en[i] = token[i] & !stall_req[i] & !halted.
  - When stage_en fires, the token rotates to i+1, or to 0 from the last stage. instret increments on the wrap from the last stage.
  - pc_redirect = redirect & token[BRANCH_STAGE] & !stall_req[BRANCH_STAGE] & !halted. No flush is needed.
- Halt:
  - halt_req & stage_valid[HALT_STAGE] sets halted the next cycle.
  - The instruction in HALT_STAGE does not advance in the cycle halt_req is seen, so stage_en[HALT_STAGE] = 0 that cycle.
  - Older instructions may drain only in that same cycle. Once halted=1, all stage_en are 0.
  - stage_valid and instret freeze; only reset clears halted.
- Simultaneous events:
  - redirect and halt_req in the same cycle: halt wins; redirect is not acknowledged.
  - stall and redirect in BRANCH_STAGE: wait for the stall to clear.
  - reset overrides everything, including mid-stall and mid-flush.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- With it defined, two extra outputs exist:
  - stall_cycles (CNT_W): increments each cycle where any hold[i] & stage_valid[i], not halted.
  - flush_count (CNT_W): increments per acknowledged redirect.
  - Both reset to 0.
- Without it, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - stage index constants F_STAGE=0, D_STAGE=1, E_STAGE=2, M_STAGE=3, W_STAGE=4.
  - Default CNT_W.
  - Typedef for the stage bit-vector.
- Sub-module pipe_ctrl_counter: CNT_W-bit counter with synchronous reset and enable. It is instantiated for cycle, instret and the two perf counters.

Test Plan:
- Pipelined mode: reset, then 10 cycles with no stalls → stage_valid=5'b11111 from cycle 5; instret=1 after cycle 5; instret=6 after cycle 10.
- Pipelined mode: stall_req[1]=1 for 2 cycles with the pipe full → stage_en=5'b11100 both cycles; stage_valid[2] goes to 0 (bubble) and refills after release; instret skips 2 increments.
- Pipelined mode: redirect with stage_valid[3]=1 → pc_redirect=1 that cycle; the next cycle has stage_valid[3:1]=3'b000 and stage_valid[4]=1; instret counts only the branch and older instructions.
- Token mode: reset, then 15 cycles → token sequence 1,2,4,8,16 repeating; instret=3 after 15 cycles; stall_req[2]=1 for 1 cycle delays the wrap by 1 cycle.
- halt_req with stage_valid[2]=1 → halted=1 next cycle; stage_en=0 thereafter; cycle keeps incrementing while instret is constant; reset then clears halted=0 and instret=0.
- Feature enabled: 3 stall cycles plus 2 acknowledged redirects → stall_cycles=3, flush_count=2; reset → both 0.
